// File: rtl/nios_pio_seq_pkg.sv
// Shared constants and types for the PIO pattern sequencer.
package nios_pio_seq_pkg;

  localparam int unsigned DepthDefault   = 8;
  localparam int unsigned DataWDefault   = 3;
  localparam int unsigned PeriodWDefault = 24;

  // Configuration slave word offsets; PAT entries live at 8..15 (address bit 3 set).
  localparam logic [3:0] AddrCtrl   = 4'd0;
  localparam logic [3:0] AddrStatus = 4'd1;
  localparam logic [3:0] AddrPeriod = 4'd2;
  localparam logic [3:0] AddrLength = 4'd3;

  localparam int unsigned CtrlRunBit    = 0;
  localparam int unsigned CtrlLoopBit   = 1;
  localparam int unsigned CtrlIrqEnBit  = 2;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StWait  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/nios_system_pio_sequencer_if.sv
// Configuration slave port plus master port toward the downstream PIO.
interface nios_system_pio_sequencer_if;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  // Sequencer side.
  modport slave (
    input  s_address, s_chipselect, s_write_n, s_writedata,
    output s_readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );

  // Host / PIO side.
  modport master (
    output s_address, s_chipselect, s_write_n, s_writedata,
    input  s_readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );
endinterface

// File: rtl/nios_pio_seq_tick.sv
// Loadable down-counter that paces the gap between PIO writes.
module nios_pio_seq_tick
  import nios_pio_seq_pkg::*;
#(
  parameter int unsigned WIDTH = PeriodWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);
  logic [WIDTH-1:0] count_q, count_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Flags the enabled cycle whose decrement reaches zero.
  assign zero = enable && (count_q <= WIDTH'(1));
endmodule

// File: rtl/nios_system_pio_sequencer.sv
// Plays a short table of patterns into a PIO slave at a programmable period.
module nios_system_pio_sequencer
  import nios_pio_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned PERIOD_W = PeriodWDefault,
  parameter int unsigned DEPTH    = DepthDefault
) (
  input logic                         clk,
  input logic                         reset,
  nios_system_pio_sequencer_if.slave  bus
);
  seq_state_e          state_q, state_d;
  logic                run_q, run_d, loop_q, irq_en_q, done_q, done_d;
  logic [PERIOD_W-1:0] period_q, tick_value;
  logic [2:0]          length_q, index_q, index_d;
  logic [DATA_W-1:0]   pat_q [DEPTH];
  logic                wr_en, ctrl_wr, status_wr, period_wr, length_wr, pat_wr, abort;
  logic                tick_load, tick_zero, in_write;
  logic                unused_wdata;

  assign wr_en     = bus.s_chipselect && !bus.s_write_n;
  assign ctrl_wr   = wr_en && (bus.s_address == AddrCtrl);
  assign status_wr = wr_en && (bus.s_address == AddrStatus);
  assign period_wr = wr_en && (bus.s_address == AddrPeriod);
  assign length_wr = wr_en && (bus.s_address == AddrLength);
  assign pat_wr    = wr_en && bus.s_address[3];
  assign abort     = ctrl_wr && !bus.s_writedata[CtrlRunBit] && (state_q != StIdle);
  assign in_write  = (state_q == StWrite);
  assign tick_value = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign unused_wdata = ^bus.s_writedata;

  nios_pio_seq_tick #(
    .WIDTH (PERIOD_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .load       (tick_load),
    .load_value (tick_value),
    .enable     (state_q == StWait),
    .zero       (tick_zero)
  );

  // Next state, sequence index, run and done flags.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    run_d     = ctrl_wr ? bus.s_writedata[CtrlRunBit] : run_q;
    done_d    = (status_wr && bus.s_writedata[StatusDoneBit]) ? 1'b0 : done_q;
    tick_load = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_wr && bus.s_writedata[CtrlRunBit]) begin
            state_d = StWrite;
            index_d = '0;
          end
        end
        StWrite: begin
          tick_load = 1'b1;
          state_d   = StWait;
        end
        StWait: begin
          if (tick_zero) begin
            // >= so a LENGTH shrunk below the index ends the sequence.
            if (index_q < length_q) begin
              index_d = index_q + 3'd1;
              state_d = StWrite;
            end else if (loop_q) begin
              index_d = '0;
              state_d = StWrite;
            end else begin
              done_d  = 1'b1;  // overrides a same-edge W1C
              run_d   = 1'b0;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Register file and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      index_q  <= '0;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      run_q   <= run_d;
      done_q  <= done_d;
      if (ctrl_wr) begin
        loop_q   <= bus.s_writedata[CtrlLoopBit];
        irq_en_q <= bus.s_writedata[CtrlIrqEnBit];
      end
      if (period_wr) period_q <= bus.s_writedata[PERIOD_W-1:0];
      if (length_wr) length_q <= bus.s_writedata[2:0];
      if (pat_wr)    pat_q[bus.s_address[2:0]] <= bus.s_writedata[DATA_W-1:0];
    end
  end

  // Zero-wait-state register read mux.
  always_comb begin
    bus.s_readdata = '0;
    if (bus.s_address[3]) begin
      bus.s_readdata[DATA_W-1:0] = pat_q[bus.s_address[2:0]];
    end else begin
      case (bus.s_address)
        AddrCtrl:   bus.s_readdata[2:0] = {irq_en_q, loop_q, run_q};
        AddrStatus: bus.s_readdata[1:0] = {done_q, state_q != StIdle};
        AddrPeriod: bus.s_readdata[PERIOD_W-1:0] = period_q;
        AddrLength: bus.s_readdata[2:0] = length_q;
        default:    bus.s_readdata = '0;
      endcase
    end
  end

  // Master strobe is live only in the single WRITE cycle.
  always_comb begin
    bus.m_address    = 2'd0;
    bus.m_chipselect = in_write;
    bus.m_write_n    = !in_write;
    bus.m_writedata  = in_write ? 32'(pat_q[index_q]) : 32'd0;
    bus.irq          = done_q && irq_en_q;
  end
endmodule

// File: doc/nios_system_pio_sequencer.md
NIOS_SYSTEM_PIO_SEQUENCER -- requirements
Module: nios_system_pio_sequencer

Interface
REQ-001 Parameter: DATA_W, default 3, width of the pattern entries and of the downstream PIO data field.
REQ-002 Parameter: PERIOD_W, default 24, width of the PERIOD register and of the tick counter.
REQ-003 Parameter: DEPTH, default 8, number of pattern table entries; fixed at 8 for this block.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 s_address  input  4  configuration slave word address.
REQ-007 s_chipselect  input  1  configuration slave select.
REQ-008 s_write_n  input  1  configuration slave write strobe, active-low.
REQ-009 s_writedata  input  32  configuration slave write data.
REQ-010 s_readdata  output  32  configuration slave read data; combinational, zero wait states, unused bits 0.
REQ-011 m_address  output  2  master address to the downstream PIO slave; always 0.
REQ-012 m_chipselect  output  1  master select to the PIO.
REQ-013 m_write_n  output  1  master write strobe to the PIO, active-low.
REQ-014 m_writedata  output  32  master write data; bits [DATA_W-1:0] carry the pattern, upper bits 0.
REQ-015 irq  output  1  level interrupt, equal to STATUS.done AND CTRL.irq_en.

Function
REQ-016 Register map (s_address): 0 CTRL {bit0 run, bit1 loop, bit2 irq_en}; 1 STATUS {bit0 busy (RO), bit1 done (W1C)}; 2 PERIOD [PERIOD_W-1:0]; 3 LENGTH [2:0], sequence length = LENGTH+1; 8..15 PAT[0..7] [DATA_W-1:0]; other addresses read 0, writes ignored.
REQ-017 Slave write accepted when s_chipselect=1 and s_write_n=0; it takes effect on the same rising edge.
REQ-018 FSM states: IDLE, WRITE, WAIT; busy = (state != IDLE).
REQ-019 IDLE -> WRITE on the edge after a CTRL write with run=1; index cleared to 0; done is not cleared by this transition.
REQ-020 WRITE lasts exactly one cycle: m_chipselect=1, m_write_n=0, m_writedata=PAT[index]; next state WAIT, tick counter loaded with max(PERIOD,1).
REQ-021 WAIT decrements the counter each cycle; on reaching 0: if index != LENGTH, index+1 and go to WRITE; else if loop=1, index=0 and go to WRITE; else set done, clear run, go to IDLE.
REQ-022 Spacing between consecutive master write cycles is max(PERIOD,1)+1 clocks; latency from the CTRL run-write edge to the first master write cycle is 1 clock.
REQ-023 CTRL write with run=0 in any non-IDLE state forces IDLE on the next edge, issues no further master write, leaves done unchanged, and the PIO holds its last value.
REQ-024 CTRL write with run=1 while busy updates loop/irq_en only and does not restart the sequence.
REQ-025 PERIOD/LENGTH writes while busy take effect at the next counter load / index comparison; a PAT write takes effect for any entry not yet written.
REQ-026 If LENGTH is reduced below the current index, the sequence ends at the next WAIT expiry (comparison uses index >= LENGTH).
REQ-027 Setting done and a software W1C of done on the same edge: set wins.
REQ-028 Outside WRITE: m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0.

Reset
REQ-029 reset asserts asynchronously: state=IDLE, all registers, PAT entries, index and counter cleared to 0.
REQ-030 During and after reset: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0, s_readdata reflects cleared registers.
REQ-031 Reset mid-sequence aborts immediately with no partial master write; release is synchronous to clk.

Structure
REQ-032 Package nios_pio_seq_pkg holds register offsets, CTRL/STATUS bit positions, the FSM state enum, and the DEPTH/DATA_W/PERIOD_W defaults.
REQ-033 One sub-module, nios_pio_seq_tick: loadable down-counter with load, enable and zero outputs.

Verification
REQ-034 PAT={1,2,4}, LENGTH=2, PERIOD=3, loop=0, run=1 -> master writes 1,2,4 at 4-clock spacing, then done=1, busy=0, run=0.
REQ-035 Same as REQ-034 with loop=1 and irq_en=1 -> writes 1,2,4,1,2,... continue, irq remains 0; a run=0 write after the second write -> no third write, busy=0 one clock later.
REQ-036 PERIOD=0, LENGTH=0, PAT[0]=7 -> a single write of 7, one WAIT cycle, then done=1 and irq=1 with irq_en=1.
REQ-037 W1C of done on the same edge that done is set -> done reads 1; a following W1C -> done=0, irq=0.
REQ-038 reset asserted during WAIT with PERIOD=100 -> outputs idle within the same cycle, all registers read 0, no master write after release.
